// File: rtl/sram_pkg.sv
// Shared types for the dual-port SRAM with clear sweep: FSM state encoding and
// read-during-write mode selectors.
package sram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sram_clr_fsm.sv
// Clear-sweep sequencer: walks every address once, writing zero, then idles.
//
//   state | meaning
//   IDLE  | data ports active, waiting for clr_req
//   CLEAR | one zero-write per cycle at clr_addr, data ports ignored
module sram_clr_fsm
  import sram_pkg::*;
#(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDRWIDTH-1:0] clr_addr
);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          addr_d  = '0;
        end
      end
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = addr_q;

endmodule

// File: rtl/sram_dp_clr.sv
// Simple dual-port SRAM (one write, one registered read port) with byte enables,
// selectable read-during-write behaviour and a full-memory zero sweep.
module sram_dp_clr
  import sram_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int RDW_MODE  = RDW_OLD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   wr_en,
  input  logic [ADDRWIDTH-1:0]   wr_addr,
  input  logic [DATAWIDTH-1:0]   wr_data,
  input  logic [DATAWIDTH/8-1:0] wr_be,
  input  logic                   rd_en,
  input  logic [ADDRWIDTH-1:0]   rd_addr,
  output logic [DATAWIDTH-1:0]   rd_data,
  output logic                   rd_valid
);

  localparam int NBYTES = DATAWIDTH / 8;
  localparam int DEPTH  = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic                 clr_we;
  logic [ADDRWIDTH-1:0] clr_addr;
  logic [DATAWIDTH-1:0] wr_merged;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_waddr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 rd_accept;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q;

  sram_clr_fsm #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_clr_fsm (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int k = 0; k < NBYTES; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  // The sweep owns the write port while busy; user traffic is dropped, not queued.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    if (!reset) begin
      if (busy) begin
        mem_we    = clr_we;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_accept = !reset && !busy && rd_en;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_accept) begin
      if (RDW_MODE == RDW_NEW && wr_en && (wr_addr == rd_addr)) rd_data_d = wr_merged;
      else                                                       rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_accept;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sram_dp_clr.sv
// Bench for sram_dp_clr: two instances (old-data and new-data read-during-write)
// share stimulus; a memory-array reference model checks every cycle.
module tb_sram_dp_clr;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clr_req, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          busy0, busy1, rdv0, rdv1;
  logic [DW-1:0] rd0, rd1;

  sram_dp_clr #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RDW_MODE(0)) u_old (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rdv0)
  );

  sram_dp_clr #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RDW_MODE(1)) u_new (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rdv1)
  );

  int total = 0;
  int bad   = 0;
  int busy_run = 0;

  // Reference model: plain word array plus "sweep cycles remaining".
  logic [DW-1:0] m_mem [DEPTH];
  int            m_sweep_left = 0;
  logic          m_rdv = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [DW-1:0] old_w, new_w;
    if (reset) begin
      m_sweep_left = DEPTH;
      m_rdv = 1'b0;
      m_rd0 = '0;
      m_rd1 = '0;
    end else if (m_sweep_left > 0) begin
      m_mem[DEPTH - m_sweep_left] = '0;
      m_sweep_left--;
      m_rdv = 1'b0;
    end else begin
      old_w = m_mem[wr_addr];
      new_w = old_w;
      for (int k = 0; k < 4; k++) if (wr_be[k]) new_w[8*k +: 8] = wr_data[8*k +: 8];
      m_rdv = rd_en;
      if (rd_en) begin
        m_rd0 = m_mem[rd_addr];
        m_rd1 = (wr_en && wr_addr == rd_addr) ? new_w : m_mem[rd_addr];
      end
      if (wr_en) m_mem[wr_addr] = new_w;
      if (clr_req) m_sweep_left = DEPTH;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (busy0) busy_run++;
    check("busy_old", 32'(busy0), 32'(m_sweep_left > 0));
    check("busy_new", 32'(busy1), 32'(m_sweep_left > 0));
    check("rdv_old",  32'(rdv0),  32'(m_rdv));
    check("rdv_new",  32'(rdv1),  32'(m_rdv));
    check("rd_old",   rd0, m_rd0);
    check("rd_new",   rd1, m_rd1);
  endtask

  task automatic quiet();
    reset = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy0; i++) cycle();
    check(name, 32'(busy0), 32'd0);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [3:0] be,
                              logic re, logic [AW-1:0] ra, logic ev, logic [DW-1:0] e0,
                              logic [DW-1:0] e1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
    v.ev = ev; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  int rdv_seen;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h00, 1, 32'h0,        32'h0));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h80, 1, 32'h0,        32'h0));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'hFF, 1, 32'h0,        32'h0));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 0, 32'h0,        32'h0));
    vt.push_back(mk(1, 8'h10, 32'hAABBCCDD, 4'hF, 0, 8'h00, 0, 32'h0,        32'h0));
    vt.push_back(mk(1, 8'h10, 32'h11223344, 4'h5, 0, 8'h00, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 1, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 8'h00, 0, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 1, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(1, 8'h20, 32'h33,       4'hF, 0, 8'h00, 0, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(1, 8'h20, 32'h5A,       4'hF, 1, 8'h20, 1, 32'h33,       32'h5A));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h20, 1, 32'h5A,       32'h5A));
    vt.push_back(mk(1, 8'h30, 32'h77,       4'hF, 1, 8'h10, 1, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 1, 8'h30, 1, 32'h77,       32'h77));
    vt.push_back(mk(1, 8'h10, 32'h0000EE00, 4'h2, 1, 8'h10, 1, 32'hAA22CC44, 32'hAA22EE44));
    for (int a = 1; a <= 4; a++)
      vt.push_back(mk(1, AW'(a), DW'(a), 4'hF, 0, 8'h00, 0, 32'hAA22CC44, 32'hAA22EE44));
    for (int a = 1; a <= 4; a++)
      vt.push_back(mk(0, 8'h00, 32'h0, 4'h0, 1, AW'(a), 1, DW'(a), DW'(a)));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 0, 32'h4,        32'h4));
    vt.push_back(mk(0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 0, 32'h4,        32'h4));

    // Power-up reset and first sweep.
    quiet();
    reset = 1'b1;
    wr_en = 1'b1; wr_be = 4'hF; rd_en = 1'b1;
    busy_run = 0;
    cycle();
    check("reset_busy",  32'(busy0), 32'd1);
    check("reset_rdv",   32'(rdv0),  32'd0);
    check("reset_rdata", rd0,        32'd0);
    quiet();
    wait_idle("init_sweep_end");
    check("init_sweep_len", 32'(busy_run), 32'd256);

    // Directed vectors.
    foreach (vt[i]) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      cycle();
      check($sformatf("vec%0d_valid", i), 32'(rdv0), 32'(vt[i].ev));
      check($sformatf("vec%0d_rd_old", i), rd0, vt[i].e0);
      check($sformatf("vec%0d_rd_new", i), rd1, vt[i].e1);
    end
    quiet();

    // Clear sweep ignores data ports and a repeated clr_req.
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 32'hFF; wr_be = 4'hF;
    cycle();
    quiet();
    clr_req = 1'b1;
    busy_run = 0;
    cycle();
    clr_req = 1'b0;
    check("clr_start", 32'(busy0), 32'd1);
    for (int i = 0; i < 2; i++) cycle();
    wr_en = 1'b1; wr_addr = 8'h06; wr_data = 32'hEE; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'h05;
    cycle();
    check("sweep_rd_ignored", 32'(rdv0), 32'd0);
    quiet();
    for (int i = 0; i < 6; i++) cycle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    wait_idle("clr_sweep_end");
    check("clr_sweep_len", 32'(busy_run), 32'd256);
    rd_en = 1'b1; rd_addr = 8'h05;
    cycle();
    check("clr_rd05", rd0, 32'h0);
    check("clr_rd05_v", 32'(rdv0), 32'd1);
    rd_addr = 8'h06;
    cycle();
    check("clr_rd06", rd1, 32'h0);
    quiet();

    // Reset in the middle of a sweep restarts it.
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) cycle();
    reset = 1'b1; rd_en = 1'b1; rd_addr = 8'h03;
    busy_run = 0;
    rdv_seen = 0;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 400 && busy0; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 255));
      wr_data = $urandom; wr_be = 4'($urandom_range(0, 15));
      cycle();
      if (rdv0 || rdv1) rdv_seen++;
    end
    check("mid_reset_idle", 32'(busy0), 32'd0);
    check("mid_reset_len", 32'(busy_run), 32'd256);
    check("mid_reset_rdv", 32'(rdv_seen), 32'd0);
    quiet();

    // Random traffic against the model, tight address range for collisions.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 999) == 0);
      clr_req = ($urandom_range(0, 299) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7));
      rd_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      cycle();
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
